// File: rtl/boot_sequencer.sv
// Boot sequencer: hands fetch to the BIOS, then copies the OS image from disk to instruction memory.
// It resets the PC and switches fetch to main memory for good; all outputs are registered except the instrucao mux.
module boot_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int OS_SIZE   = 310,
    parameter int DISK_BASE = 0,
    parameter int OS_BASE   = 0,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              biosFinalizada,
    input  logic [DATA_W-1:0] instrucaoBios,
    input  logic [DATA_W-1:0] instrucaoMemoria,
    output logic [DATA_W-1:0] instrucao,
    output logic              cpuStall,
    output logic              pcReset,
    output logic              fonteSO,
    output logic              discoLer,
    output logic [ADDR_W-1:0] discoEndereco,
    input  logic [DATA_W-1:0] discoDado,
    input  logic              discoValido,
    output logic              memEscrever,
    output logic [ADDR_W-1:0] memEndereco,
    output logic [DATA_W-1:0] memDado,
    output logic              erro,
    output logic [2:0]        estado
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX    = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  LAST_WORD   = CNT_W'((OS_SIZE > 0) ? OS_SIZE - 1 : 0);
    localparam logic [ADDR_W-1:0] DISK_BASE_A = ADDR_W'(DISK_BASE);
    localparam logic [ADDR_W-1:0] OS_BASE_A   = ADDR_W'(OS_BASE);
    localparam bit                HAS_IMAGE   = (OS_SIZE > 0);

    typedef enum logic [2:0] {
        S_BIOS    = 3'd0,
        S_REQ     = 3'd1,
        S_WR      = 3'd2,
        S_HANDOFF = 3'd3,
        S_OS      = 3'd4,
        S_ERRO    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;

    logic               cpuStall_q, cpuStall_d;
    logic               pcReset_q, pcReset_d;
    logic               fonteSO_q, fonteSO_d;
    logic               discoLer_q, discoLer_d;
    logic [ADDR_W-1:0]  discoEndereco_q, discoEndereco_d;
    logic               memEscrever_q, memEscrever_d;
    logic [ADDR_W-1:0]  memEndereco_q, memEndereco_d;
    logic [DATA_W-1:0]  memDado_q, memDado_d;
    logic               erro_q, erro_d;
    logic               capture;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_BIOS;
            cnt_q           <= '0;
            wait_q          <= '0;
            cpuStall_q      <= 1'b0;
            pcReset_q       <= 1'b0;
            fonteSO_q       <= 1'b0;
            discoLer_q      <= 1'b0;
            discoEndereco_q <= '0;
            memEscrever_q   <= 1'b0;
            memEndereco_q   <= '0;
            memDado_q       <= '0;
            erro_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            wait_q          <= wait_d;
            cpuStall_q      <= cpuStall_d;
            pcReset_q       <= pcReset_d;
            fonteSO_q       <= fonteSO_d;
            discoLer_q      <= discoLer_d;
            discoEndereco_q <= discoEndereco_d;
            memEscrever_q   <= memEscrever_d;
            memEndereco_q   <= memEndereco_d;
            memDado_q       <= memDado_d;
            erro_q          <= erro_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        case (state_q)
            S_BIOS: begin
                if (biosFinalizada) begin
                    state_d = HAS_IMAGE ? S_REQ : S_HANDOFF;
                end
            end
            S_REQ: begin
                if (discoValido) begin
                    wait_d  = '0;
                    state_d = S_WR;
                end else begin
                    // saturating: once at the limit the word has timed out
                    wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
                    if (wait_d == WAIT_MAX) begin
                        state_d = S_ERRO;
                    end
                end
            end
            S_WR: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST_WORD) ? S_HANDOFF : S_REQ;
            end
            S_HANDOFF: state_d = S_OS;
            S_OS:      state_d = S_OS;
            S_ERRO:    state_d = S_ERRO;
            default:   state_d = S_BIOS;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q after the edge.
    always_comb begin
        capture         = (state_q == S_REQ) && discoValido;
        cpuStall_d      = (state_d == S_REQ) || (state_d == S_WR) ||
                          (state_d == S_HANDOFF) || (state_d == S_ERRO);
        pcReset_d       = (state_d == S_HANDOFF);
        fonteSO_d       = (state_d == S_OS);
        discoLer_d      = (state_d == S_REQ);
        memEscrever_d   = (state_d == S_WR);
        erro_d          = (state_d == S_ERRO);
        discoEndereco_d = discoEndereco_q;
        if (state_d == S_REQ) begin
            discoEndereco_d = DISK_BASE_A + cnt_d[ADDR_W-1:0];
        end
        memDado_d       = capture ? discoDado : memDado_q;
        memEndereco_d   = capture ? (OS_BASE_A + cnt_q[ADDR_W-1:0]) : memEndereco_q;
    end

    always_comb begin
        if (fonteSO_q) begin
            instrucao = instrucaoMemoria;
        end else if (state_q == S_BIOS) begin
            instrucao = instrucaoBios;
        end else begin
            instrucao = '0;
        end
    end

    assign cpuStall      = cpuStall_q;
    assign pcReset       = pcReset_q;
    assign fonteSO       = fonteSO_q;
    assign discoLer      = discoLer_q;
    assign discoEndereco = discoEndereco_q;
    assign memEscrever   = memEscrever_q;
    assign memEndereco   = memEndereco_q;
    assign memDado       = memDado_q;
    assign erro          = erro_q;
    assign estado        = state_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: three instances (3-word image with short timeout, 310-word image, empty image).
// A disk model answers reads after a programmable delay; expected writes are queued and checked as they appear.
module tb_boot_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  bf;
    logic [31:0] ibios, imem;
    logic [31:0] ddat [3];
    logic [2:0]  dval;

    logic [31:0] instr [3];
    logic [2:0]  stall, pcr, fso, ler, mwr, err;
    logic [15:0] dend [3];
    logic [15:0] mend [3];
    logic [31:0] mdat [3];
    logic [2:0]  est  [3];

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t sb [$];

    int n_vec = 0;
    int n_err = 0;
    int act   = 0;
    int dly   [3];
    int dwait [3];
    int kidx  [3];
    int nwr   [3];
    int nler  [3];
    int npcr  [3];
    int last_addr;
    int cyc;
    int nwr_before;

    always #5 clock = ~clock;

    boot_sequencer #(.OS_SIZE(3), .TIMEOUT(8)) u_dut0 (
        .clock(clock), .reset(reset), .biosFinalizada(bf[0]),
        .instrucaoBios(ibios), .instrucaoMemoria(imem), .instrucao(instr[0]),
        .cpuStall(stall[0]), .pcReset(pcr[0]), .fonteSO(fso[0]),
        .discoLer(ler[0]), .discoEndereco(dend[0]), .discoDado(ddat[0]), .discoValido(dval[0]),
        .memEscrever(mwr[0]), .memEndereco(mend[0]), .memDado(mdat[0]),
        .erro(err[0]), .estado(est[0])
    );

    boot_sequencer #(.OS_SIZE(310)) u_dut1 (
        .clock(clock), .reset(reset), .biosFinalizada(bf[1]),
        .instrucaoBios(ibios), .instrucaoMemoria(imem), .instrucao(instr[1]),
        .cpuStall(stall[1]), .pcReset(pcr[1]), .fonteSO(fso[1]),
        .discoLer(ler[1]), .discoEndereco(dend[1]), .discoDado(ddat[1]), .discoValido(dval[1]),
        .memEscrever(mwr[1]), .memEndereco(mend[1]), .memDado(mdat[1]),
        .erro(err[1]), .estado(est[1])
    );

    boot_sequencer #(.OS_SIZE(0)) u_dut2 (
        .clock(clock), .reset(reset), .biosFinalizada(bf[2]),
        .instrucaoBios(ibios), .instrucaoMemoria(imem), .instrucao(instr[2]),
        .cpuStall(stall[2]), .pcReset(pcr[2]), .fonteSO(fso[2]),
        .discoLer(ler[2]), .discoEndereco(dend[2]), .discoDado(ddat[2]), .discoValido(dval[2]),
        .memEscrever(mwr[2]), .memEndereco(mend[2]), .memDado(mdat[2]),
        .erro(err[2]), .estado(est[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bf    = 3'b000;
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            kidx[i] = 0;
            nwr[i]  = 0;
            nler[i] = 0;
            npcr[i] = 0;
        end
    endtask

    // Monitor first (scoreboard pop), then the disk model drives the next strobe.
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (ler[i]) nler[i]++;
            if (pcr[i]) npcr[i]++;
            if (mwr[i]) begin
                nwr[i]++;
                if (i == act) begin
                    if (sb.size() == 0) begin
                        check("unexpected_write", 32'(mend[i]), 32'hFFFF_FFFF);
                    end else begin
                        wr_t e;
                        e = sb.pop_front();
                        check("wr_addr", 32'(mend[i]), 32'(e.a));
                        check("wr_data", mdat[i], e.d);
                        last_addr = int'(mend[i]);
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            dval[i] = 1'b0;
            if (ler[i] && !reset) begin
                if (dwait[i] >= dly[i]) begin
                    dval[i]  = 1'b1;
                    ddat[i]  = 32'hA0 + 32'(dend[i]);
                    dwait[i] = 0;
                    if (i == act) begin
                        check("disk_addr", 32'(dend[i]), 32'(kidx[i]));
                        sb.push_back({16'(kidx[i]), 32'hA0 + 32'(kidx[i])});
                    end
                    kidx[i]++;
                end else begin
                    dwait[i]++;
                end
            end else begin
                dwait[i] = 0;
            end
        end
    end

    initial begin
        reset = 1'b1;
        bf    = 3'b000;
        ibios = 32'h6800_0400;
        imem  = 32'h1234_5678;
        dval  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            ddat[i]  = '0;
            dly[i]   = 0;
            dwait[i] = 0;
        end
        last_addr = -1;

        // reset state
        tick(2);
        check("rst_estado", 32'(est[0]), 0);
        check("rst_stall", 32'(stall[0]), 0);
        check("rst_ler", 32'(ler[0]), 0);
        check("rst_pcr", 32'(pcr[0]), 0);
        check("rst_fso", 32'(fso[0]), 0);
        check("rst_err", 32'(err[0]), 0);
        check("rst_mwr", 32'(mwr[0]), 0);
        check("rst_mem_dat", mdat[1], 0);
        do_reset();

        // BIOS idle for 20 cycles
        tick(20);
        check("bios_estado", 32'(est[0]), 0);
        check("bios_instr", instr[0], 32'h6800_0400);
        check("bios_stall", 32'(stall[0]), 0);
        check("bios_nler", 32'(nler[0]), 0);
        check("bios_nwr", 32'(nwr[0]), 0);

        // 3-word copy, disk answers 2 cycles after each read request
        act    = 0;
        dly[0] = 2;
        bf[0]  = 1'b1;
        tick(1);
        check("copy_first_ler", 32'(ler[0]), 1);
        check("copy_estado_req", 32'(est[0]), 1);
        check("copy_stall", 32'(stall[0]), 1);
        check("copy_nop", instr[0], 0);
        cyc = 0;
        for (int c = 0; c < 200; c++) begin
            tick(1);
            cyc++;
            if (pcr[0]) break;
        end
        check("copy_cycles_to_pcreset", cyc, 12);
        check("copy_nwr", 32'(nwr[0]), 3);
        check("copy_sb_empty", sb.size(), 0);
        check("handoff_estado", 32'(est[0]), 3);
        check("handoff_stall", 32'(stall[0]), 1);
        tick(1);
        check("os_pcr", 32'(pcr[0]), 0);
        check("os_fso", 32'(fso[0]), 1);
        check("os_stall", 32'(stall[0]), 0);
        check("os_estado", 32'(est[0]), 4);
        check("os_instr", instr[0], 32'h1234_5678);
        imem = 32'hCAFE_0001;
        bf[0] = 1'b0;
        #1;
        check("os_instr_mux", instr[0], 32'hCAFE_0001);
        tick(5);
        check("os_terminal", 32'(est[0]), 4);
        check("os_npcr", 32'(npcr[0]), 1);

        // timeout: disk never answers
        do_reset();
        check("to_rst_estado", 32'(est[0]), 0);
        dly[0] = 100000;
        bf[0]  = 1'b1;
        tick(1);
        check("to_req", 32'(est[0]), 1);
        tick(7);
        check("to_still_req", 32'(est[0]), 1);
        check("to_no_err_yet", 32'(err[0]), 0);
        tick(1);
        check("to_estado", 32'(est[0]), 5);
        check("to_err", 32'(err[0]), 1);
        check("to_stall", 32'(stall[0]), 1);
        check("to_ler", 32'(ler[0]), 0);
        check("to_instr", instr[0], 0);
        tick(5);
        check("to_sticky", 32'(err[0]), 1);
        check("to_nwr", 32'(nwr[0]), 0);

        // 310 words, disk answers on the first request cycle
        do_reset();
        act       = 1;
        dly[1]    = 0;
        last_addr = -1;
        bf[1]     = 1'b1;
        tick(1);
        check("fast_first_ler", 32'(ler[1]), 1);
        cyc = 0;
        for (int c = 0; c < 2000; c++) begin
            tick(1);
            cyc++;
            if (est[1] == 3'd3) break;
        end
        check("fast_cycles", cyc, 620);
        check("fast_nwr", 32'(nwr[1]), 310);
        check("fast_last_addr", last_addr, 309);
        check("fast_sb_empty", sb.size(), 0);

        // reset during WR of word 5
        do_reset();
        dly[1] = 2;
        bf[1]  = 1'b1;
        cyc    = 0;
        for (int c = 0; c < 200; c++) begin
            tick(1);
            cyc++;
            if (mwr[1] && mend[1] == 16'd5) break;
        end
        check("mid_reached_word5", 32'(mend[1]), 5);
        reset = 1'b1;
        bf[1] = 1'b0;
        tick(1);
        check("mid_estado", 32'(est[1]), 0);
        check("mid_stall", 32'(stall[1]), 0);
        check("mid_ler", 32'(ler[1]), 0);
        check("mid_mwr", 32'(mwr[1]), 0);
        check("mid_dend", 32'(dend[1]), 0);
        check("mid_mend", 32'(mend[1]), 0);
        check("mid_mdat", mdat[1], 0);
        reset = 1'b0;
        nwr_before = nwr[1];
        tick(10);
        check("mid_nwr_total", 32'(nwr[1]), 6);
        check("mid_no_more_wr", nwr[1] - nwr_before, 0);
        check("mid_sb_empty", sb.size(), 0);

        // re-boot starts again from word 0
        kidx[1]   = 0;
        nwr[1]    = 0;
        last_addr = -1;
        bf[1]     = 1'b1;
        tick(1);
        check("reboot_dend", 32'(dend[1]), 0);
        for (int c = 0; c < 2000; c++) begin
            tick(1);
            if (est[1] == 3'd4) break;
        end
        check("reboot_estado", 32'(est[1]), 4);
        check("reboot_nwr", 32'(nwr[1]), 310);
        check("reboot_last_addr", last_addr, 309);

        // empty image: straight to handoff
        do_reset();
        act   = 2;
        bf[2] = 1'b1;
        tick(1);
        check("empty_estado", 32'(est[2]), 3);
        check("empty_pcr", 32'(pcr[2]), 1);
        check("empty_stall", 32'(stall[2]), 1);
        tick(1);
        check("empty_os", 32'(est[2]), 4);
        check("empty_fso", 32'(fso[2]), 1);
        tick(5);
        check("empty_npcr", 32'(npcr[2]), 1);
        check("empty_nler", 32'(nler[2]), 0);
        check("empty_nwr", 32'(nwr[2]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
